serial_chunk_adder: RTL and testbench

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder.sv | 120 ++++++++++++
 tb/tb_serial_chunk_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock, LSB slice first.
// Define SERIAL_CHUNK_ADDER_SUB_EN to add the sub port and a - b support.
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             sub_eff;
  logic             load, step, last_slice;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right as slices are consumed, so the active slice is always the low CHUNK bits.
  assign last_slice = (idx_q == IDX_W'(N - 1));
  assign slice_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  assign acc_next   = (acc_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // NOTE: the partial-sum and operand registers are plain flops, not memories, so they are all reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s       <= '0;
      co      <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= sub_eff ? ~b : b;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= sub_eff;
    end else if (step) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      acc_q   <= acc_next;
      idx_q   <= idx_q + 1'b1;
      carry_q <= slice_sum[CHUNK];
      // Results are published only on the final slice so s never shows a partial sum.
      if (last_slice) begin
        s  <= acc_next;
        co <= slice_sum[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: WIDTH=8/CHUNK=4 instance plus a WIDTH=4/CHUNK=1 instance.
module tb_serial_chunk_adder;

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [7:0] a, b;
  logic       busy, done, co;
  logic [7:0] s;

  logic       rst4, start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, co4;
  logic [3:0] s4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .co(co)
  );

  serial_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy4), .done(done4), .s(s4), .co(co4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] exp_s;
    logic       exp_co;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 8-bit instance: checks busy length, stable s, result and done width.
  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vsub, input logic [7:0] es, input logic eco);
    logic [7:0] prev_s;
    int busy_cnt, cyc;
    prev_s = s;
    a = va; b = vb; sub = vsub; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      check({name, " s_hold"}, s, prev_s);
      tick();
      cyc++;
    end
    check({name, " done_seen"}, done, 1'b1);
    check({name, " busy_cycles"}, busy_cnt, 2);
    check({name, " busy_in_done"}, busy, 1'b0);
    check({name, " s"}, s, es);
    check({name, " co"}, co, eco);
    tick();
    check({name, " done_one_cycle"}, done, 1'b0);
  endtask

  task automatic run_op4(input string name, input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] es, input logic eco);
    int busy_cnt, cyc;
    a4 = va; b4 = vb; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      if (busy4) busy_cnt++;
      tick();
      cyc++;
    end
    check({name, " done_seen"}, done4, 1'b1);
    check({name, " busy_cycles"}, busy_cnt, 4);
    check({name, " s"}, s4, es);
    check({name, " co"}, co4, eco);
    tick();
    check({name, " done_one_cycle"}, done4, 1'b0);
  endtask

  initial begin
    int cyc;
    logic saw_done;

    vecs.push_back('{8'd10,  8'd15,  1'b0, 8'd25,  1'b0});
    vecs.push_back('{8'd200, 8'd100, 1'b0, 8'd44,  1'b1});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd15,  8'd1,   1'b0, 8'd16,  1'b0});
    vecs.push_back('{8'd128, 8'd128, 1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd0,   8'd0,   1'b0, 8'd0,   1'b0});
    vecs.push_back('{8'd170, 8'd85,  1'b0, 8'd255, 1'b0});
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    vecs.push_back('{8'd5,   8'd7,   1'b1, 8'd254, 1'b0});
    vecs.push_back('{8'd7,   8'd5,   1'b1, 8'd2,   1'b1});
    vecs.push_back('{8'd9,   8'd9,   1'b1, 8'd0,   1'b1});
    vecs.push_back('{8'd0,   8'd1,   1'b1, 8'd255, 1'b0});
`endif

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    tick();
    tick();
    rst = 1'b0; rst4 = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset s", s, 8'd0);
    check("reset co", co, 1'b0);

    // Re-pulsed start with new operands during BUSY and DONE must be ignored.
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    a = 8'd50; b = 8'd50;
    cyc = 0;
    while (!done && cyc < 20) begin
      check("repulse s_hold", s, 8'd0);
      tick();
      cyc++;
    end
    check("repulse done_seen", done, 1'b1);
    check("repulse s", s, 8'd3);
    check("repulse co", co, 1'b0);
    tick();
    start = 1'b0;
    check("repulse no_done", done, 1'b0);
    check("repulse busy_after", busy, 1'b0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_s, vecs[i].exp_co);

    // Reset during the second BUSY cycle aborts with no done pulse.
    a = 8'd200; b = 8'd100; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort in_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort s", s, 8'd0);
    check("abort co", co, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    check("abort stays_idle", saw_done, 1'b0);
    run_op("after_abort", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0);

    // Start asserted together with reset is ignored.
    a = 8'd9; b = 8'd9; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start busy", busy, 1'b0);
    tick();
    check("rst_start busy2", busy, 1'b0);
    check("rst_start done", done, 1'b0);
    check("rst_start s", s, 8'd0);

    run_op4("w4c1 0+1", 4'd0, 4'd1, 4'd1, 1'b0);
    run_op4("w4c1 10+15", 4'd10, 4'd15, 4'd9, 1'b1);
    run_op4("w4c1 15+1", 4'd15, 4'd1, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
